// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown arbiter slice.
// Purpose : timer state encoding, default sizing and the interval clamp rule
//           used by both the arbiter and the timer core.
// Contents: state_t, CNT_WIDTH_DEFAULT, MAX_AMOUNT_DEFAULT, clamp_amount().
package countdown_pkg;

  localparam int CNT_WIDTH_DEFAULT  = 16;
  localparam int MAX_AMOUNT_DEFAULT = 22;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Map a requested interval onto the legal range [1, max_amount].
  // Operands are zero-extended to 32 bits by the caller, so the compare sees
  // the full counter-width value with no truncation.
  function automatic logic [31:0] clamp_amount(input logic [31:0] amount,
                                               input logic [31:0] max_amount);
    logic [31:0] eff;
    if (amount == 32'd0) begin
      eff = 32'd1;
    end else if (amount > max_amount) begin
      eff = max_amount;
    end else begin
      eff = amount;
    end
    return eff;
  endfunction

endpackage

// File: rtl/countdown_arbiter_if.sv
// Requester-side bus of the countdown arbiter.
// Purpose : bundles the request/grant handshake, the completion pulses and
//           the shared-timer status.
// Signals : req__ENA   request strobes (held until granted)
//           req_amount per-requester interval, slice i = [i*CNT_WIDTH +: CNT_WIDTH]
//           req__RDY   grant, one-hot or zero
//           done       one-cycle completion pulse to the owner
//           busy       shared timer running
//           busy__RDY  constant 1
//           owner      current or last granted requester
// Modports: master = requesters, slave = arbiter.
interface countdown_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 16,
  parameter int IDX_W     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]           req__ENA;
  logic [NUM_REQ*CNT_WIDTH-1:0] req_amount;
  logic [NUM_REQ-1:0]           req__RDY;
  logic [NUM_REQ-1:0]           done;
  logic                         busy;
  logic                         busy__RDY;
  logic [IDX_W-1:0]             owner;

  modport master (
    output req__ENA, req_amount,
    input  req__RDY, done, busy, busy__RDY, owner
  );

  modport slave (
    input  req__ENA, req_amount,
    output req__RDY, done, busy, busy__RDY, owner
  );
endinterface

// File: rtl/countdown_arbiter_chk.sv
// Invariant checker for countdown_arbiter, only built for formal runs.
// Purpose : counter range, grant/done exclusivity and handshake ordering.
// Ports   : CLK, nRST plus the arbiter's observable state.
`ifdef FORMAL
module countdown_arbiter_chk #(
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_AMOUNT = 22,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input logic                 CLK,
  input logic                 nRST,
  input logic [CNT_WIDTH-1:0] counter,
  input logic                 running,
  input logic                 accept,
  input logic [NUM_REQ-1:0]   req__RDY,
  input logic [NUM_REQ-1:0]   done,
  input logic                 busy
);
  a_cnt_range : assert property (@(posedge CLK) 32'(counter) < MAX_AMOUNT);
  a_rdy_onehot: assert property (@(posedge CLK) $onehot0(req__RDY));
  a_done_onehot: assert property (@(posedge CLK) $onehot0(done));
  a_no_rdy_busy: assert property (@(posedge CLK) busy |-> (req__RDY == '0));
  a_done_zero : assert property (@(posedge CLK)
                                 (done != '0) |-> (running && counter == '0));
  a_accept_busy: assert property (@(posedge CLK) disable iff (!nRST)
                                  accept |=> busy);
endmodule
`endif

// File: rtl/countdown_core.sv
// Countdown timer datapath.
// Purpose : loads an interval minus one while idle, then counts down to zero
//           and returns to idle on the cycle it sits at zero.
// Ports   : CLK, nRST (sync, active-low), load, load_value,
//           counter_zero, running, counter (for observation/checking).
module countdown_core
  import countdown_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 counter_zero,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] counter
);

  state_t               state_r;
  logic [CNT_WIDTH-1:0] counter_r;

  // Timer FSM: load in IDLE, decrement in RUN, leave RUN when counter is zero.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r   <= IDLE;
      counter_r <= {CNT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (load) begin
            counter_r <= load_value;
            state_r   <= RUN;
          end else begin
            counter_r <= counter_r;
            state_r   <= IDLE;
          end
        end
        RUN: begin
          // Decrement only when nonzero so the counter can never wrap.
          if (counter_r != {CNT_WIDTH{1'b0}}) begin
            counter_r <= counter_r - CNT_WIDTH'(1);
            state_r   <= RUN;
          end else begin
            counter_r <= counter_r;
            state_r   <= IDLE;
          end
        end
        default: begin
          counter_r <= {CNT_WIDTH{1'b0}};
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign running      = (state_r == RUN);
  assign counter_zero = (counter_r == {CNT_WIDTH{1'b0}});
  assign counter      = counter_r;

endmodule

// File: rtl/countdown_arbiter.sv
// Round-robin front end for the shared busy/countdown timer.
// Purpose : grants one timed-interval request at a time, loads the shared
//           countdown_core with the clamped interval and pulses done to the
//           owning requester when the interval ends.
// Ports   : CLK, nRST (sync, active-low), bus (countdown_arbiter_if.slave).
module countdown_arbiter
  import countdown_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT,
  parameter int MAX_AMOUNT = MAX_AMOUNT_DEFAULT,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input logic                CLK,
  input logic                nRST,
  countdown_arbiter_if.slave bus
);

  logic [IDX_W-1:0]     rr_ptr_r;
  logic [IDX_W-1:0]     owner_r;
  logic                 grant_found_s;
  logic [IDX_W-1:0]     grant_idx_s;
  int                   scan_idx_s;
  logic                 grant_en_s;
  logic [CNT_WIDTH-1:0] amount_s;
  logic [CNT_WIDTH-1:0] eff_s;
  logic [CNT_WIDTH-1:0] load_value_s;
  logic [IDX_W-1:0]     next_ptr_s;
  logic                 core_zero_s;
  logic                 core_running_s;
  logic [CNT_WIDTH-1:0] core_counter_s;

  // Round-robin scan starting at rr_ptr; the first pending request wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {IDX_W{1'b0}};
    scan_idx_s    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx_s = (int'(rr_ptr_r) + k) % NUM_REQ;
      if (!grant_found_s && bus.req__ENA[scan_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = IDX_W'(scan_idx_s);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Grants are withheld while the timer runs and during reset, so a request
  // pending at reset time is not accepted.
  assign grant_en_s = nRST && !core_running_s && grant_found_s;

  assign amount_s     = bus.req_amount[int'(grant_idx_s)*CNT_WIDTH +: CNT_WIDTH];
  assign eff_s        = CNT_WIDTH'(clamp_amount(32'(amount_s), 32'(MAX_AMOUNT)));
  assign load_value_s = eff_s - CNT_WIDTH'(1);
  assign next_ptr_s   = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}}
                                                             : grant_idx_s + IDX_W'(1);

  countdown_core #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_core (
    .CLK          (CLK),
    .nRST         (nRST),
    .load         (grant_en_s),
    .load_value   (load_value_s),
    .counter_zero (core_zero_s),
    .running      (core_running_s),
    .counter      (core_counter_s)
  );

  // Owner and rotation pointer advance only in the acceptance cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rr_ptr_r <= {IDX_W{1'b0}};
      owner_r  <= {IDX_W{1'b0}};
    end else if (grant_en_s) begin
      rr_ptr_r <= next_ptr_s;
      owner_r  <= grant_idx_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
      owner_r  <= owner_r;
    end
  end

  assign bus.req__RDY  = grant_en_s ? (NUM_REQ'(1) << grant_idx_s) : {NUM_REQ{1'b0}};
  // Completion is decoded from registered timer state; reset suppresses it.
  assign bus.done      = (nRST && core_running_s && core_zero_s) ?
                         (NUM_REQ'(1) << owner_r) : {NUM_REQ{1'b0}};
  assign bus.busy      = core_running_s;
  assign bus.busy__RDY = 1'b1;
  assign bus.owner     = owner_r;

`ifdef FORMAL
  countdown_arbiter_chk #(
    .NUM_REQ    (NUM_REQ),
    .CNT_WIDTH  (CNT_WIDTH),
    .MAX_AMOUNT (MAX_AMOUNT),
    .IDX_W      (IDX_W)
  ) u_chk (
    .CLK      (CLK),
    .nRST     (nRST),
    .counter  (core_counter_s),
    .running  (core_running_s),
    .accept   (grant_en_s),
    .req__RDY (bus.req__RDY),
    .done     (bus.done),
    .busy     (bus.busy)
  );
`endif

endmodule

// File: tb/tb_countdown_arbiter.sv
// Self-checking bench for countdown_arbiter: directed openers, then random
// requests/amounts/resets compared cycle by cycle against a remaining-cycles
// reference model.
module tb_countdown_arbiter;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int MAX = 22;
  localparam int IW  = $clog2(N);

  logic CLK;
  logic nRST;

  countdown_arbiter_if #(.NUM_REQ(N), .CNT_WIDTH(W)) bus ();

  countdown_arbiter #(
    .NUM_REQ    (N),
    .CNT_WIDTH  (W),
    .MAX_AMOUNT (MAX)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: busy cycles still to come (0 = idle), owner, next start.
  int m_rem   = 0;
  int m_owner = 0;
  int m_ptr   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff_of(input int amount);
    if (amount == 0) return 1;
    if (amount > MAX) return MAX;
    return amount;
  endfunction

  // One clock: drive at negedge, check settled outputs, advance model at posedge.
  task automatic do_cycle(input logic [N-1:0] ena, input logic [N*W-1:0] amts,
                          input logic rst_n, output int granted);
    int g;
    int idx;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_done;
    @(negedge CLK);
    nRST           = rst_n;
    bus.req__ENA   = ena;
    bus.req_amount = amts;
    #1;
    g = -1;
    if (rst_n && m_rem == 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && ena[idx]) g = idx;
      end
    end
    exp_rdy  = (g >= 0) ? N'(1 << g) : '0;
    exp_done = (rst_n && m_rem == 1) ? N'(1 << m_owner) : '0;
    check_eq("req_rdy",   32'(bus.req__RDY), 32'(exp_rdy));
    check_eq("done",      32'(bus.done),     32'(exp_done));
    check_eq("busy",      32'(bus.busy),     32'(m_rem > 0));
    check_eq("owner",     32'(bus.owner),    32'(m_owner));
    check_eq("busy_rdy",  32'(bus.busy__RDY), 32'd1);
    @(posedge CLK);
    if (!rst_n) begin
      m_rem = 0; m_ptr = 0; m_owner = 0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
    end else if (g >= 0) begin
      m_rem   = eff_of(int'(amts[g*W +: W]));
      m_owner = g;
      m_ptr   = (g + 1) % N;
    end
    granted = g;
  endtask

  function automatic logic [W-1:0] rand_amount();
    case ($urandom_range(0, 9))
      0: return W'(0);
      1: return W'(1);
      2: return W'(MAX);
      3: return W'(MAX + 1);
      4: return W'(100);
      5: return {W{1'b1}};
      default: return W'($urandom_range(2, 8));
    endcase
  endfunction

  initial begin
    logic [N-1:0]   ena;
    logic [N*W-1:0] amts;
    int             g;
    int             rst_hold;
    nRST = 1'b0;
    bus.req__ENA   = '0;
    bus.req_amount = '0;

    // Reset state.
    repeat (2) do_cycle('0, '0, 1'b0, g);

    // Single request: requester 2, amount 5, then idle long enough to finish.
    amts = '0;
    amts[2*W +: W] = W'(5);
    do_cycle(4'b0100, amts, 1'b1, g);
    repeat (7) do_cycle('0, amts, 1'b1, g);

    // Contention: everyone pending with amount 1.
    for (int i = 0; i < N; i++) amts[i*W +: W] = W'(1);
    repeat (12) do_cycle('1, amts, 1'b1, g);

    // Clamp extremes: 0 and 100 from requester 1.
    amts[1*W +: W] = W'(0);
    do_cycle(4'b0010, amts, 1'b1, g);
    repeat (3) do_cycle('0, amts, 1'b1, g);
    amts[1*W +: W] = W'(100);
    do_cycle(4'b0010, amts, 1'b1, g);
    repeat (25) do_cycle('0, amts, 1'b1, g);

    // Random traffic with occasional mid-run resets.
    ena = '0;
    g = -1;
    rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        amts[i*W +: W] = rand_amount();
        if (ena[i]) begin
          if (g == i) ena[i] = ($urandom_range(0, 1) == 0);
          else if ($urandom_range(0, 9) == 0) ena[i] = 1'b0;
        end else begin
          ena[i] = ($urandom_range(0, 2) == 0);
        end
      end
      if (rst_hold == 0 && $urandom_range(0, 299) == 0) rst_hold = $urandom_range(1, 2);
      do_cycle(ena, amts, (rst_hold == 0), g);
      if (rst_hold > 0) rst_hold--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
